// File: rtl/mic3_sched_pkg.sv
// Shared types and constants for the PMOD MIC3 conversion sequencer.
package mic3_sched_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, ACCUM} state_t;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;
  localparam int OUT_BITS   = 24;
  localparam logic [DATA_BITS-1:0] MID_SCALE = 12'h800;
endpackage

// File: rtl/mic3_spi_frame.sv
// One ADC frame: CS setup, 16 SCK periods shifting SDO MSB first, CS hold, then a
// one-cycle ACCUM slot that presents the 12 data bits on raw with done.
module mic3_spi_frame
  import mic3_sched_pkg::*;
#(
  parameter int sck_half = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sdo,
  output logic                 cs,
  output logic                 sck,
  output logic                 idle,
  output logic                 done,
  output logic [DATA_BITS-1:0] raw
);
  localparam int HW = $clog2(sck_half + 1);

  state_t                 state, state_nxt;
  logic [HW-1:0]          hcnt;
  logic                   phase;
  logic [3:0]             bcnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   half_end;

  assign half_end = (hcnt == HW'(sck_half - 1));

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = SETUP;
      SETUP: if (half_end) state_nxt = SHIFT;
      SHIFT: if (half_end && phase && bcnt == 4'd15) state_nxt = HOLD;
      HOLD:  if (half_end) state_nxt = ACCUM;
      ACCUM: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cs   = !(state == SETUP || state == SHIFT || state == HOLD);
    sck  = (state == SHIFT) && phase;
    idle = (state == IDLE);
    done = (state == ACCUM);
    raw  = shreg;
  end

  // Only 12 bits are kept: the four leading frame bits fall off the top.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hcnt  <= '0;
      phase <= 1'b0;
      bcnt  <= '0;
      shreg <= '0;
    end else if (state == SETUP || state == SHIFT || state == HOLD) begin
      hcnt <= half_end ? '0 : hcnt + 1'b1;
      if (state == SHIFT && half_end) begin
        phase <= ~phase;
        if (!phase) shreg <= {shreg[DATA_BITS-2:0], sdo};
        else        bcnt  <= bcnt + 1'b1;
      end
    end else begin
      hcnt  <= '0;
      phase <= 1'b0;
      bcnt  <= '0;
    end
endmodule

// File: rtl/mic3_sample_scheduler.sv
// PMOD MIC3 sample scheduler: rate tick, offset removal, decimating average and a
// one-entry output register. Define MIC3_DC_TRACK_EN to add running DC removal.
module mic3_sample_scheduler
  import mic3_sched_pkg::*;
#(
  parameter int clk_mhz    = 100,
  parameter int sample_hz  = 48000,
  parameter int sck_half   = 2,
  parameter int decim_log2 = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  output logic                cs,
  output logic                sck,
  input  logic                sdo,
  output logic [OUT_BITS-1:0] sample,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  input  logic                clear_overrun
);
  localparam int PERIOD = clk_mhz * 1_000_000 / sample_hz;
  localparam int RW     = $clog2(PERIOD);
  localparam int AW     = DATA_BITS + decim_log2;
  localparam int CW     = decim_log2 + 1;

  if (PERIOD <= 34 * sck_half + 2) begin : g_bad_period
    $fatal(1, "mic3_sample_scheduler: period too short for one frame");
  end
  if (sck_half < 1 || decim_log2 < 0 || decim_log2 > 6) begin : g_bad_param
    $fatal(1, "mic3_sample_scheduler: sck_half or decim_log2 out of range");
  end

  logic [RW-1:0]               rate;
  logic                        tick, idle, done;
  logic [DATA_BITS-1:0]        raw;
  logic signed [DATA_BITS-1:0] x, res, y;
  logic signed [AW-1:0]        acc, sum, shifted;
  logic [CW-1:0]               cnt;
  logic                        grp_end, res_vld;

  assign tick = (rate == RW'(PERIOD - 1));

  always_ff @(posedge clk or negedge rst)
    if (!rst) rate <= '0;
    else      rate <= tick ? '0 : rate + 1'b1;

  mic3_spi_frame #(.sck_half(sck_half)) u_frame (
    .clk   (clk),
    .rst   (rst),
    .start (tick && enable),
    .sdo   (sdo),
    .cs    (cs),
    .sck   (sck),
    .idle  (idle),
    .done  (done),
    .raw   (raw)
  );

  assign x       = raw - MID_SCALE;
  assign sum     = acc + AW'(x);
  assign shifted = sum >>> decim_log2;
  assign grp_end = (cnt == CW'((1 << decim_log2) - 1));

  // Partial groups are dropped whenever the sequencer sits idle with enable low.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc     <= '0;
      cnt     <= '0;
      res     <= '0;
      res_vld <= 1'b0;
    end else begin
      res_vld <= 1'b0;
      if (idle && !enable) begin
        acc <= '0;
        cnt <= '0;
      end else if (done) begin
        if (grp_end) begin
          acc     <= '0;
          cnt     <= '0;
          res     <= shifted[DATA_BITS-1:0];
          res_vld <= 1'b1;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end

`ifdef MIC3_DC_TRACK_EN
  // dc is Q12.6; its integer part is subtracted, then it leaks toward the result.
  logic signed [17:0]          dc;
  logic signed [DATA_BITS-1:0] dc_int;
  logic signed [12:0]          diff;
  logic signed [18:0]          err, step;

  assign dc_int = dc[17:6];
  assign diff   = 13'(res) - 13'(dc_int);
  assign err    = {res[DATA_BITS-1], res, 6'b0} - 19'(dc);
  assign step   = err >>> 10;

  always_comb begin
    y = diff[DATA_BITS-1:0];
    if (diff > 13'sd2047)       y = 12'sh7FF;
    else if (diff < -13'sd2048) y = 12'sh800;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst)         dc <= '0;
    else if (res_vld) dc <= dc + step[17:0];
`else
  assign y = res;
`endif

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (res_vld && (!sample_valid || sample_ready)) begin
        sample       <= {{(OUT_BITS-DATA_BITS){y[DATA_BITS-1]}}, y};
        sample_valid <= 1'b1;
      end else if (sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (res_vld && sample_valid && !sample_ready) overrun <= 1'b1;
      else if (clear_overrun)                       overrun <= 1'b0;
    end
endmodule

// File: tb/tb_mic3_sample_scheduler.sv
// Scoreboard bench for mic3_sample_scheduler: an ADC model serves queued 12-bit codes,
// the stimulus pushes expected samples, a monitor pops them on each handshake.
module tb_mic3_sample_scheduler;
  localparam int PERIOD = 100;

  logic        clk = 1'b0;
  logic        rst, enable, sdo, sample_ready, clear_overrun;
  logic        cs, sck, sample_valid, overrun;
  logic [23:0] sample;

  mic3_sample_scheduler #(
    .clk_mhz(100), .sample_hz(1_000_000), .sck_half(2), .decim_log2(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .cs            (cs),
    .sck           (sck),
    .sdo           (sdo),
    .sample        (sample),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ADC model: bits 15:12 are junk, unqueued frames read mid-scale.
  logic [11:0] adc_q[$];
  logic [15:0] word = 16'h5800;
  int          bi = 16;
  int          frames = 0;
  always @(negedge cs) begin
    bi = 0;
    if (adc_q.size() != 0) word = {4'h5, adc_q.pop_front()};
    else                   word = 16'h5800;
  end
  always @(negedge sck) if (!cs) bi++;
  always @(posedge cs) frames++;
  assign sdo = (!cs && bi < 16) ? word[15-bi] : 1'b0;

  logic [23:0] exp_q[$];
  logic [23:0] e;
  int          n_cmp = 0, n_bad = 0, got = 0;
  int          hs_cyc[$];

  always @(negedge clk)
    if (rst === 1'b1 && sample_valid && sample_ready) begin
      got++;
      hs_cyc.push_back(cyc);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_sample got %h with nothing expected", sample);
      end else begin
        e = exp_q.pop_front();
        if (sample !== e) begin
          n_bad++;
          $display("FAIL sample got %h expected %h", sample, e);
        end
      end
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_got(input int n);
    int t = 0;
    while (got < n && t < 6000) begin @(negedge clk); t++; end
    if (got < n) chk("timeout_samples", got, n);
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (frames < n && t < 6000) begin @(negedge clk); t++; end
    if (frames < n) chk("timeout_frames", frames, n);
  endtask

  task automatic wait_sig(input string name, input logic want, input bit use_sck);
    int t = 0;
    while ((use_sck ? sck : cs) !== want && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) chk(name, {31'd0, use_sck ? sck : cs}, {31'd0, want});
  endtask

  task automatic push(input logic [11:0] v, input int n);
    repeat (n) adc_q.push_back(v);
  endtask

  task automatic run(input int n_out);
    int base;
    base = got;
    enable = 1'b1;
    wait_got(base + n_out);
    enable = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int f0, base, lowc, rises, seen;
    logic prev;
    rst = 1'b0; enable = 1'b0; sample_ready = 1'b1; clear_overrun = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", cs, 1); chk("rst_sck", sck, 0); chk("rst_sample", sample, 0);
    chk("rst_valid", sample_valid, 0); chk("rst_overrun", overrun, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    push(12'h900, 4); exp_q.push_back(24'h000100); run(1);

    push(12'hA00, 8); exp_q.push_back(24'h000200); exp_q.push_back(24'h000200); run(2);
    chk("out_spacing", hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-2], 4 * PERIOD);

    push(12'h000, 4); push(12'hFFF, 4);
    exp_q.push_back(24'hFFF800); exp_q.push_back(24'h0007FF); run(2);

    push(12'h900, 1); push(12'h700, 1); push(12'h900, 1); push(12'h700, 1);
    exp_q.push_back(24'h000000); run(1);

    push(12'h801, 1); push(12'h800, 3); push(12'h7FF, 1); push(12'h800, 3);
    exp_q.push_back(24'h000000); exp_q.push_back(24'hFFFFFF); run(2);

    // Stalled consumer: first result kept, two later ones dropped.
    sample_ready = 1'b0;
    push(12'hA00, 4); push(12'h000, 4); push(12'hFFF, 4);
    exp_q.push_back(24'h000200);
    f0 = frames; base = got;
    enable = 1'b1;
    wait_frames(f0 + 12);
    repeat (4) @(negedge clk);
    enable = 1'b0;
    chk("stall_sample", sample, 24'h000200);
    chk("stall_valid", sample_valid, 1);
    chk("stall_overrun", overrun, 1);
    clear_overrun = 1'b1; @(negedge clk); clear_overrun = 1'b0;
    chk("overrun_cleared", overrun, 0);
    sample_ready = 1'b1;
    wait_got(base + 1);
    repeat (5) @(negedge clk);

    // Ready rises exactly in the cycle the next result arrives.
    sample_ready = 1'b0;
    push(12'hA00, 4); push(12'h000, 4);
    exp_q.push_back(24'h000200); exp_q.push_back(24'hFFF800);
    f0 = frames; base = got;
    enable = 1'b1;
    wait_frames(f0 + 8);
    chk("pending_valid", sample_valid, 1);
    @(posedge clk); #1 sample_ready = 1'b1;
    wait_got(base + 2);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_overrun_same_cycle", overrun, 0);

    // Frame shape, with enable dropped inside the frame.
    base = got;
    enable = 1'b1;
    wait_sig("cs_fall", 1'b0, 1'b0);
    enable = 1'b0;
    lowc = 0; rises = 0; prev = 1'b0;
    while (cs === 1'b0 && lowc < 200) begin
      lowc++;
      if (sck && !prev) rises++;
      prev = sck;
      @(negedge clk);
    end
    chk("cs_low_cycles", lowc, 68);
    chk("sck_rises", rises, 16);
    seen = 0;
    repeat (3 * PERIOD) begin @(negedge clk); if (cs !== 1'b1) seen++; end
    chk("no_cs_after_disable", seen, 0);
    chk("no_partial_output", got, base);

    // Asynchronous reset in the middle of SHIFT with a sample pending.
    sample_ready = 1'b0;
    push(12'hA00, 4);
    f0 = frames;
    enable = 1'b1;
    wait_frames(f0 + 4);
    repeat (4) @(negedge clk);
    chk("pre_reset_valid", sample_valid, 1);
    wait_sig("cs_fall2", 1'b0, 1'b0);
    wait_sig("sck_high", 1'b1, 1'b1);
    chk("pre_reset_sck", sck, 1);
    rst = 1'b0;
    #1;
    chk("reset_cs", cs, 1); chk("reset_sck", sck, 0);
    chk("reset_valid", sample_valid, 0); chk("reset_sample", sample, 0);
    enable = 1'b0; sample_ready = 1'b1;
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);

    push(12'hA00, 4); exp_q.push_back(24'h000200); run(1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
